// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared UART frame constants, state encodings and bit-period helper
package uart_link_pkg;

    // Start bit + 8 data bits + stop bit
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_LOWHOLD,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Bit period in clocks, rounded to nearest
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_link_tx.sv
// rtl/uart_link_tx.sv - UART transmitter, 8N1, LSB first
//   clk, reset       : clock, synchronous active-high reset
//   tx_valid/tx_data : byte offered for transmission
//   tx_ready         : high while idle; a byte is taken on tx_valid && tx_ready
//   tx               : serial line, idle high, registered
module uart_link_tx
    import uart_link_pkg::*;
#(
    parameter int DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam int DATA_BITS = FRAME_BITS - 2;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        shreg    <= tx_data;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        cnt      <= '0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            // shreg[0] is on the line; bit 1 goes next
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        tx_ready <= 1'b1;
                        state    <= TX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= TX_IDLE;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_link.sv
// rtl/uart_link.sv - host UART front end: byte receiver with holding register, break detect, transmitter
//   clk, reset          : clock, synchronous active-high reset
//   rx                  : asynchronous serial input, idle high
//   rx_valid/rx_data    : received byte, held until rx_ready
//   tx_valid/tx_data    : byte to send; tx_ready high when transmitter idle
//   tx                  : serial output, idle high
//   brk                 : one-cycle pulse when the line has been low for BREAK_BITS bit times
//   framing_err         : one-cycle pulse, stop bit sampled low
//   rx_overrun          : one-cycle pulse, completed byte dropped because holding register full
module uart_link
    import uart_link_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int BREAK_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       brk,
    output logic       framing_err,
    output logic       rx_overrun
);

    localparam int DIV       = calc_div(CLK_FREQ, BAUD);
    localparam int HALF      = DIV / 2;
    localparam int BREAK_LEN = BREAK_BITS * DIV;
    localparam int CW        = $clog2(BREAK_LEN + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BRK_LAST  = CW'(BREAK_LEN - 1);
    localparam logic [CW-1:0] BRK_MAX   = CW'(BREAK_LEN);

    logic          rx_meta;
    logic          rs;
    logic          rs_prev;
    logic [CW-1:0] low_cnt;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_done;
    logic          brk_hit;
    logic          xfer;

    // Synchroniser plus a run-length counter of the current low period on rs.
    // The counter restarts on every high cycle, so in LOWHOLD it equals the
    // cycles since the start edge only if the line never rose in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
            rs_prev <= 1'b1;
            low_cnt <= '0;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
            rs_prev <= rs;
            if (rs) begin
                low_cnt <= '0;
            end else if (low_cnt != BRK_MAX) begin
                low_cnt <= low_cnt + 1'b1;
            end
        end
    end

    assign brk_hit = (state == RX_LOWHOLD) && !rs && (low_cnt >= BRK_LAST);
    assign xfer    = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_done     <= 1'b0;
            brk         <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rx_done     <= 1'b0;
            brk         <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rs_prev && !rs) begin
                        cnt   <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (rs) begin
                            rx_done <= 1'b1;
                            state   <= RX_IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= RX_LOWHOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_LOWHOLD: begin
                    if (rs) begin
                        state <= RX_IDLE;
                    end else if (brk_hit) begin
                        brk   <= 1'b1;
                        state <= RX_WAIT_IDLE;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rs) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // One-entry holding register; a byte completing in the same cycle as a
    // transfer replaces the outgoing one without counting as an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (brk_hit) begin
                rx_valid <= 1'b0;
            end else if (rx_done) begin
                if (!rx_valid || xfer) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (xfer) begin
                rx_valid <= 1'b0;
            end
        end
    end

    uart_link_tx #(
        .DIV (DIV)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx)
    );

endmodule
